// File: rtl/frequency_meter.sv
`default_nettype none
// ============================================================================
// frequency_meter: counts rising edges of signal_in over a GATE_CYCLES window
// Revision: 1.0
// ============================================================================
module frequency_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int GATE_WIDTH  = 26,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   signal_in,
  output logic [COUNT_WIDTH-1:0] freq_out,
  output logic                   valid,
  output logic                   overflow
);

  localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  logic                   s1;
  logic                   s2;
  logic                   s3;
  logic [GATE_WIDTH-1:0]  gate_count;
  logic [COUNT_WIDTH-1:0] edge_count;
  logic                   ovf_acc;

  logic rise;
  logic saturated;
  logic terminal;

  assign rise      = s2 & ~s3;
  assign saturated = (edge_count == COUNT_MAX);
  assign terminal  = enable && (gate_count == GATE_LAST);

  always_ff @(posedge clock) begin
    if (clear) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      gate_count <= '0;
      edge_count <= '0;
      ovf_acc    <= 1'b0;
      freq_out   <= '0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // Synchronizer keeps sampling while paused so stale edges age out.
      s1    <= signal_in;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;
      if (terminal) begin
        // An edge in the terminal cycle belongs to the window being closed.
        freq_out   <= (rise && !saturated) ? edge_count + COUNT_ONE : edge_count;
        overflow   <= ovf_acc | (rise & saturated);
        valid      <= 1'b1;
        gate_count <= '0;
        edge_count <= '0;
        ovf_acc    <= 1'b0;
      end else if (enable) begin
        gate_count <= gate_count + GATE_WIDTH'(1);
        if (rise) begin
          if (saturated) begin
            ovf_acc <= 1'b1;
          end else begin
            edge_count <= edge_count + COUNT_ONE;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frequency_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_frequency_meter: directed stimulus with queue-based scoreboard
// Revision: 1.0
// ============================================================================
module tb_frequency_meter;

  logic        clock = 1'b0;
  logic        clear_a;
  logic        clear_b;
  logic        enable;
  logic        signal_in;
  logic [15:0] freq_a;
  logic        valid_a;
  logic        ovf_a;
  logic [3:0]  freq_b;
  logic        valid_b;
  logic        ovf_b;

  always #5 clock = ~clock;

  frequency_meter #(.GATE_CYCLES(100), .GATE_WIDTH(7), .COUNT_WIDTH(16)) dut_a (
    .clock(clock), .clear(clear_a), .enable(enable), .signal_in(signal_in),
    .freq_out(freq_a), .valid(valid_a), .overflow(ovf_a)
  );

  frequency_meter #(.GATE_CYCLES(100), .GATE_WIDTH(7), .COUNT_WIDTH(4)) dut_b (
    .clock(clock), .clear(clear_b), .enable(enable), .signal_in(signal_in),
    .freq_out(freq_b), .valid(valid_b), .overflow(ovf_b)
  );

  typedef struct {
    int cyc;
    int freq;
    bit ovf;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int release_cyc = 0;
  int ph          = 0;
  int period      = 10;
  int high        = 5;
  int offset      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic wave(int j);
    return ((j + offset) % period) < high;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ph++;
    signal_in = wave(ph);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic set_wave(int p, int h, int o);
    period    = p;
    high      = h;
    offset    = o;
    signal_in = wave(ph);
  endtask

  // Holds both instances in clear for k cycles, then releases the selected one.
  task automatic do_clear(bit sel, int k);
    clear_a = 1'b1;
    clear_b = 1'b1;
    run(k);
    if (sel) clear_b = 1'b0;
    else     clear_a = 1'b0;
    release_cyc = cyc;
    ph          = 1;
    signal_in   = wave(1);
  endtask

  task automatic push(bit sel, int rel, int f, bit o);
    exp_t e;
    e.cyc  = release_cyc + rel;
    e.freq = f;
    e.ovf  = o;
    if (sel) sb_b.push_back(e);
    else     sb_a.push_back(e);
  endtask

  task automatic drained(string name);
    check({name, " a pending"}, sb_a.size(), 0);
    check({name, " b pending"}, sb_b.size(), 0);
    sb_a.delete();
    sb_b.delete();
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (valid_a) begin
      if (sb_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a unexpected valid: freq %0d ovf %0d at cycle %0d, none required", freq_a, ovf_a, cyc);
      end else begin
        e = sb_a.pop_front();
        check("a valid cycle", cyc, e.cyc);
        check("a freq_out", freq_a, e.freq);
        check("a overflow", ovf_a, e.ovf);
      end
    end
    if (valid_b) begin
      if (sb_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b unexpected valid: freq %0d ovf %0d at cycle %0d, none required", freq_b, ovf_b, cyc);
      end else begin
        e = sb_b.pop_front();
        check("b valid cycle", cyc, e.cyc);
        check("b freq_out", freq_b, e.freq);
        check("b overflow", ovf_b, e.ovf);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    clear_a   = 1'b1;
    clear_b   = 1'b1;
    enable    = 1'b1;
    signal_in = 1'b0;

    // Steady 10-clock square wave: rises at samples 1, 10, 20, ...
    set_wave(10, 5, 0);
    do_clear(1'b0, 2);
    check("reset freq_a", freq_a, 0);
    check("reset valid_a", valid_a, 0);
    check("reset ovf_a", ovf_a, 0);
    check("reset freq_b", freq_b, 0);
    check("reset valid_b", valid_b, 0);
    push(1'b0, 100, 10, 1'b0);
    push(1'b0, 200, 10, 1'b0);
    push(1'b0, 300, 10, 1'b0);
    run(305);
    drained("steady");

    // Input held high through clear release counts exactly one edge.
    set_wave(1, 1, 0);
    do_clear(1'b0, 2);
    check("clear freq_a", freq_a, 0);
    check("clear valid_a", valid_a, 0);
    push(1'b0, 100, 1, 1'b0);
    push(1'b0, 200, 0, 1'b0);
    push(1'b0, 300, 0, 1'b0);
    run(305);
    drained("held high");

    // 4-bit counter: 25 edges saturate, then a slower wave recovers.
    set_wave(4, 2, 0);
    do_clear(1'b1, 2);
    push(1'b1, 100, 15, 1'b1);
    push(1'b1, 200, 5, 1'b0);
    push(1'b1, 300, 5, 1'b0);
    run(100);
    set_wave(20, 10, 0);
    run(205);
    drained("saturate");

    // Pause 37 cycles at gate phase 50 of window 2, then clear at phase 60 of window 4.
    set_wave(10, 5, 0);
    do_clear(1'b0, 2);
    push(1'b0, 100, 10, 1'b0);
    push(1'b0, 237, 10, 1'b0);
    push(1'b0, 337, 10, 1'b0);
    run(150);
    enable = 1'b0;
    check("pause freq_a", freq_a, 10);
    run(37);
    check("pause hold freq_a", freq_a, 10);
    check("pause hold ovf_a", ovf_a, 0);
    enable = 1'b1;
    run(210);
    drained("pause");
    do_clear(1'b0, 1);
    check("mid clear freq_a", freq_a, 0);
    check("mid clear ovf_a", ovf_a, 0);
    check("mid clear valid_a", valid_a, 0);
    push(1'b0, 100, 10, 1'b0);
    run(105);
    drained("mid clear");

    // Offset wave puts a rise in the terminal cycle of each window.
    set_wave(10, 5, 2);
    do_clear(1'b0, 2);
    push(1'b0, 100, 11, 1'b0);
    push(1'b0, 200, 10, 1'b0);
    run(205);
    drained("terminal edge");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frequency_meter.md
Name: frequency_meter

Overview:
- Measures the frequency of an external square wave by counting its rising edges over a fixed gate window of `clock` cycles.
- This is the inverse of the rate-divider path: the divider turns a count into a rate, and this block turns a rate into a count.
- The latched count is meant to drive the existing hex_decoder display chain, or a self-check that loops the divided clock back in.

Parameters:
- GATE_CYCLES, 50000000, gate window length in `clock` cycles (1 s at 50 MHz); legal range ≥ 2.
- GATE_WIDTH, 26, gate counter width; must satisfy 2^GATE_WIDTH ≥ GATE_CYCLES.
- COUNT_WIDTH, 16, edge counter and result width.

Ports:
- clock  input  1  system clock (CLOCK_50 at top level).
- clear  input  1  synchronous, active-high reset.
- enable  input  1  window runs while high; while low, gate counter and edge counter hold and edges are ignored.
- signal_in  input  1  asynchronous signal to be measured.
- freq_out  output  COUNT_WIDTH  rising-edge count of the last completed window.
- valid  output  1  one-cycle pulse when freq_out updates.
- overflow  output  1  last completed window saturated the edge counter.

Behaviour:
- Single clock domain. All state is updated on the posedge of `clock`.
- Reset (clear=1 at posedge): freq_out=0, valid=0, overflow=0, gate counter=0, edge counter=0, overflow accumulator=0, all three synchronizer/edge flops=0. Clear overrides enable.
- Input path: 2-flop synchronizer (s1, s2) followed by a delay flop s3.
  - edge = s2 & ~s3.
  - A low→high transition first sampled at posedge k increments the edge counter at posedge k+2.
  - Flops reset to 0, so a signal_in held high through clear release counts exactly one edge.
- Edge counter increments on edge while enable=1.
  - Saturates at 2^COUNT_WIDTH−1.
  - An edge arriving while saturated sets the window overflow accumulator.
- Gate counter counts 0..GATE_CYCLES−1 while enable=1.
- Terminal cycle (gate counter = GATE_CYCLES−1 and enable=1), all at that posedge:
  - freq_out <= edge counter + edge, saturated; an edge in the terminal cycle belongs to the closing window.
  - overflow <= accumulator | (an edge in the terminal cycle while saturated).
  - valid <= 1.
  - Gate counter, edge counter and accumulator <= 0.
- valid is 0 in every non-terminal cycle. With enable held high, consecutive windows are back-to-back with no dead cycle: valid pulses every GATE_CYCLES cycles.
- First valid occurs GATE_CYCLES cycles after clear deasserts.
- enable=0:
  - The partial window is paused, not discarded.
  - freq_out and overflow hold; valid=0.
  - Synchronizer flops keep sampling, so an edge that happened during the pause is not counted on resume unless s2 & ~s3 is still true at resume.
- Clear mid-window: the partial window is discarded, all outputs return to 0, and no valid pulse occurs.
- freq_out and overflow change only on a terminal cycle or on clear. Between pulses they are stable.
- State machine: implicit COUNTING state only. Window phase equals gate counter value; no separate idle state is required.

Test Plan:
- GATE_CYCLES=100, COUNT_WIDTH=16; clear 2 cycles; signal_in period 10 clocks (5 high/5 low), enable=1 → valid pulses at cycles 100, 200, 300 after clear release; freq_out=10 every window from window 2 on (window 1 is 9 or 10 depending on phase, checked against a model); overflow=0.
- GATE_CYCLES=100; signal_in held high through and after clear → window 1 freq_out=1; windows 2+ freq_out=0; valid still pulses every 100 cycles.
- GATE_CYCLES=100, COUNT_WIDTH=4; signal_in period 4 clocks (25 edges/window) → freq_out=15, overflow=1. Then switch to period 20 clocks → next full window freq_out=5, overflow=0.
- GATE_CYCLES=100, period 10; drop enable for 37 cycles at gate phase 50 → next valid 137 cycles after the previous one; freq_out=10 (±1, model-checked); no valid during the pause.
- Assert clear for 1 cycle at gate phase 60 → freq_out=0, overflow=0, valid=0 immediately; next valid exactly 100 cycles after clear release.
- Edge landing exactly in the terminal cycle (period tuned so edge = 1 at phase 99) → counted in the closing window's freq_out; the next window starts at 0.
